uart_tx_serializer: RTL and testbench

Serialises one byte per request onto the UART TxD line as an asynchronous 8-data-bit frame: start bit, LSB first, optional parity, one stop bit. Sits directly downstream of the transmit-button debouncer. That stage's one-cycle `transmit` pulse starts a frame carrying the byte currently on `data`, normally board switches. Provides `busy` and `done` status for LEDs or a future FIFO front end.

---
 rtl/uart_tx_serializer_if.sv | 11 +
 rtl/uart_tx_serializer.sv | 104 ++++++++++
 tb/tb_uart_tx_serializer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_serializer_if.sv
// Transmit request / serial status bundle between the request source and the UART serializer.
interface uart_tx_serializer_if;
   logic       transmit;
   logic [7:0] data;
   logic       TxD;
   logic       busy;
   logic       done;

   modport master (output transmit, output data, input TxD, input busy, input done);
   modport slave  (input transmit, input data, output TxD, output busy, output done);
endinterface

// File: rtl/uart_tx_serializer.sv
// UART frame serializer: start bit, 8 data bits LSB first, optional parity, one stop bit.
// One request per frame; requests while a frame is in flight are dropped.
module uart_tx_serializer #(
   parameter int CLK_FREQ     = 100_000_000,
   parameter int BAUD         = 9600,
   parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0
) (
   input  logic                 Clock,
   input  logic                 Reset_n,
   uart_tx_serializer_if.slave  bus
);

   localparam int               CNT_W   = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_bit_cnt;
   logic [2:0]       r_bit_idx;
   logic [7:0]       r_shift;
   logic             r_parity;
   logic             r_txd;
   logic             r_busy;
   logic             r_done;

   wire w_bit_end = (r_bit_cnt == CNT_MAX);

   assign bus.TxD  = r_txd;
   assign bus.busy = r_busy;
   assign bus.done = r_done;

   // NOTE: all state here is updated with <= so every register samples pre-edge values.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state   <= S_IDLE;
         r_bit_cnt <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_parity  <= 1'b0;
         r_txd     <= 1'b1;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state == S_IDLE) begin
            if (bus.transmit) begin
               r_shift   <= bus.data;
               r_parity  <= (^bus.data) ^ 1'(PARITY_ODD);
               r_bit_cnt <= '0;
               r_bit_idx <= '0;
               r_state   <= S_START;
               r_txd     <= 1'b0;
               r_busy    <= 1'b1;
            end
         end else begin
            r_bit_cnt <= w_bit_end ? '0 : r_bit_cnt + CNT_W'(1);
            // TxD is registered, so each boundary loads the level of the bit that follows.
            if (w_bit_end) begin
               case (r_state)
                  S_START: begin
                     r_state   <= S_DATA;
                     r_bit_idx <= '0;
                     r_txd     <= r_shift[0];
                  end
                  S_DATA: begin
                     if (r_bit_idx == 3'd7) begin
                        if (PARITY_EN != 0) begin
                           r_state <= S_PARITY;
                           r_txd   <= r_parity;
                        end else begin
                           r_state <= S_STOP;
                           r_txd   <= 1'b1;
                        end
                     end else begin
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_txd     <= r_shift[1];
                        r_bit_idx <= r_bit_idx + 3'd1;
                     end
                  end
                  S_PARITY: begin
                     r_state <= S_STOP;
                     r_txd   <= 1'b1;
                  end
                  S_STOP: begin
                     r_state <= S_IDLE;
                     r_txd   <= 1'b1;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
                  default: begin
                     r_state <= S_IDLE;
                     r_txd   <= 1'b1;
                     r_busy  <= 1'b0;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: three instances (no parity, even, odd) checked every cycle
// against a frame-image reference model, plus directed scenarios and random traffic.
module tb_uart_tx_serializer;

   localparam int CPB    = 4;
   localparam int PEN[3] = '{0, 1, 1};
   localparam int POD[3] = '{0, 0, 1};

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic [2:0] tx_req;
   logic [7:0] tx_data [3];
   logic [2:0] obs_txd, obs_busy, obs_done;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: a frame is a bit image; line level is image[cycles_into_frame / CPB].
   int          pos  [3];
   int          flen [3];
   logic [10:0] frame[3];
   logic        done_exp[3];
   int          busy_cnt[3];
   int          done_cnt[3];

   uart_tx_serializer_if if0 ();
   uart_tx_serializer_if if1 ();
   uart_tx_serializer_if if2 ();

   assign if0.transmit = tx_req[0];
   assign if1.transmit = tx_req[1];
   assign if2.transmit = tx_req[2];
   assign if0.data     = tx_data[0];
   assign if1.data     = tx_data[1];
   assign if2.data     = tx_data[2];
   assign obs_txd      = {if2.TxD,  if1.TxD,  if0.TxD};
   assign obs_busy     = {if2.busy, if1.busy, if0.busy};
   assign obs_done     = {if2.done, if1.done, if0.done};

   uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0))
      u_dut0 (.Clock(clk), .Reset_n(rst_n), .bus(if0));
   uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0))
      u_dut1 (.Clock(clk), .Reset_n(rst_n), .bus(if1));
   uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1))
      u_dut2 (.Clock(clk), .Reset_n(rst_n), .bus(if2));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic exp_txd(input int i);
      if (pos[i] >= 0 && pos[i] < flen[i]) return frame[i][pos[i] / CPB];
      return 1'b1;
   endfunction

   function automatic logic exp_busy(input int i);
      return (pos[i] >= 0 && pos[i] < flen[i]);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         pos[i]      = -1;
         done_exp[i] = 1'b0;
      end
   endtask

   task automatic model_edge(input int i);
      logic [7:0] d;
      if (!rst_n) begin
         pos[i]      = -1;
         done_exp[i] = 1'b0;
      end else begin
         done_exp[i] = 1'b0;
         if (!exp_busy(i)) begin
            if (tx_req[i]) begin
               d            = tx_data[i];
               frame[i]     = '1;
               frame[i][0]  = 1'b0;
               for (int j = 0; j < 8; j++) frame[i][1 + j] = d[j];
               if (PEN[i] != 0) frame[i][9] = (^d) ^ 1'(POD[i]);
               flen[i] = (10 + PEN[i]) * CPB;
               pos[i]  = 0;
            end else begin
               pos[i] = -1;
            end
         end else begin
            pos[i]++;
            if (pos[i] == flen[i]) done_exp[i] = 1'b1;
         end
      end
   endtask

   task automatic compare_all();
      for (int i = 0; i < 3; i++) begin
         check($sformatf("txd%0d", i),  32'(obs_txd[i]),  32'(exp_txd(i)));
         check($sformatf("busy%0d", i), 32'(obs_busy[i]), 32'(exp_busy(i)));
         check($sformatf("done%0d", i), 32'(obs_done[i]), 32'(done_exp[i]));
      end
   endtask

   task automatic step();
      @(posedge clk);
      for (int i = 0; i < 3; i++) model_edge(i);
      #1;
      compare_all();
      for (int i = 0; i < 3; i++) begin
         busy_cnt[i] += int'(obs_busy[i]);
         done_cnt[i] += int'(obs_done[i]);
      end
   endtask

   task automatic clear_counts();
      for (int i = 0; i < 3; i++) begin
         busy_cnt[i] = 0;
         done_cnt[i] = 0;
      end
   endtask

   task automatic send_all(input logic [7:0] d);
      tx_req = 3'b111;
      for (int i = 0; i < 3; i++) tx_data[i] = d;
      step();
      tx_req = 3'b000;
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic async_reset_pulse();
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      compare_all();
      run(2);
      rst_n = 1'b1;
   endtask

   initial begin
      int  done_at;
      bit  found;
      tx_req = 3'b000;
      for (int i = 0; i < 3; i++) begin
         tx_data[i] = 8'h00;
         flen[i]    = 10 * CPB;
         frame[i]   = '1;
      end
      model_reset();
      clear_counts();
      #1 rst_n = 1'b0;

      // Reset held with transmit toggling
      for (int c = 0; c < 10; c++) begin
         tx_req = (c % 2 == 1) ? 3'b111 : 3'b000;
         for (int i = 0; i < 3; i++) tx_data[i] = 8'($urandom);
         step();
      end
      tx_req = 3'b000;
      rst_n  = 1'b1;
      run(3);

      // Basic frame, data changes right after accept
      clear_counts();
      send_all(8'h55);
      for (int i = 0; i < 3; i++) tx_data[i] = 8'hFF;
      done_at = 0;
      for (int k = 2; k <= 50; k++) begin
         step();
         if (obs_done[0] && done_at == 0) done_at = k;
      end
      check("basic_busy_cycles", 32'(busy_cnt[0]), 32'd40);
      check("basic_done_cycle",  32'(done_at),     32'd41);
      check("basic_done_count",  32'(done_cnt[0]), 32'd1);
      check("even_busy_cycles",  32'(busy_cnt[1]), 32'd44);
      check("odd_busy_cycles",   32'(busy_cnt[2]), 32'd44);

      // Request during a frame is dropped
      clear_counts();
      send_all(8'hA3);
      run(14);
      send_all(8'h00);
      run(45);
      check("ignore_done_count", 32'(done_cnt[0]), 32'd1);
      check("ignore_busy",       32'(busy_cnt[0]), 32'd40);
      check("ignore_done_par",   32'(done_cnt[2]), 32'd1);

      // Back-to-back: second request issued in the done cycle
      for (int i = 0; i < 3; i++) begin
         clear_counts();
         tx_req[i]  = 1'b1;
         tx_data[i] = 8'h5A;
         step();
         tx_req = 3'b000;
         found  = 1'b0;
         for (int k = 0; k < 100; k++) begin
            step();
            if (obs_done[i]) begin
               found = 1'b1;
               break;
            end
         end
         check($sformatf("b2b_done_seen%0d", i), 32'(found), 32'd1);
         tx_req[i]  = 1'b1;
         tx_data[i] = 8'h0F;
         step();
         tx_req = 3'b000;
         run((10 + PEN[i]) * CPB + 5);
         check($sformatf("b2b_busy%0d", i), 32'(busy_cnt[i]), 32'((10 + PEN[i]) * CPB * 2));
         check($sformatf("b2b_done%0d", i), 32'(done_cnt[i]), 32'd2);
      end

      // Parity bit value for 0x07
      send_all(8'h07);
      run(37);
      check("parity_even_bit", 32'(obs_txd[1]), 32'd1);
      check("parity_odd_bit",  32'(obs_txd[2]), 32'd0);
      run(15);

      // Reset during data bit 3, then a clean frame
      clear_counts();
      send_all(8'h81);
      run(17);
      async_reset_pulse();
      run(5);
      check("abort_no_done", 32'(done_cnt[0] + done_cnt[1] + done_cnt[2]), 32'd0);
      clear_counts();
      send_all(8'h3C);
      run(50);
      check("post_reset_done", 32'(done_cnt[0]), 32'd1);
      check("post_reset_busy", 32'(busy_cnt[0]), 32'd40);

      // Random traffic with one mid-run reset
      for (int c = 0; c < 2000; c++) begin
         for (int i = 0; i < 3; i++) begin
            tx_req[i]  = ($urandom_range(0, 15) == 0);
            tx_data[i] = 8'($urandom);
         end
         if (c == 1000) begin
            tx_req = 3'b000;
            async_reset_pulse();
         end else begin
            step();
         end
      end
      tx_req = 3'b000;
      run(60);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
